// File: rtl/gpu_pkg.sv
// Shared types for the fragment depth/colour writer.
//   frag_t      : one rasterised fragment (fixed-point x/y, signed depth, 24-bit colour)
//   state_t     : writer FSM state encoding
//   PIXEL_BYTES : bytes per pixel in both colour and depth buffers
package gpu_pkg;

   localparam int unsigned PIXEL_BYTES = 4;

   typedef struct packed {
      logic signed [31:0] x;
      logic signed [31:0] y;
      logic signed [31:0] z;
      logic        [23:0] rgb;
   } frag_t;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      ZREAD,
      ZWAIT,
      ZWRITE,
      CWRITE
   } state_t;

endpackage

// File: rtl/frag_fifo.sv
// Synchronous FIFO for fragments, first-word-fall-through read port.
//   i_clk/i_rst      : clock, asynchronous active-high reset (empties the FIFO)
//   i_push/i_data    : write one entry (ignored when full)
//   i_pop            : discard the head entry (ignored when empty)
//   o_data           : current head entry
//   o_full/o_empty   : occupancy flags
module frag_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = logic [31:0]
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_push,
   input  T     i_data,
   input  logic i_pop,
   output T     o_data,
   output logic o_full,
   output logic o_empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] PTR_ONE = 1;

   T            r_mem [DEPTH];
   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   logic        w_push;
   logic        w_pop;

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop & ~o_empty;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_ONE;
         if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
   end

   assign o_data  = r_mem[r_rptr[AW-1:0]];
   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/frag_zbuf_writer.sv
// Fragment writer: buffers incoming fragments, clips them to the framebuffer, optionally
// performs a less-than depth test against the Z buffer, and writes depth and colour over an
// Avalon-MM style master port. Keeps written / depth-failed / clipped statistics.
//   CLK_clk, RESET_reset          : clock, asynchronous active-high reset
//   frag_valid/frag_ready         : fragment handshake; frag_x/y fixed-point, frag_z, frag_rgb
//   frame_pointer/z_buffer_pointer: colour and depth buffer base byte addresses
//   clear_stats                   : zero the three counters
//   busy                          : fragment in flight or buffered
//   cnt_written/zfail/clipped     : statistics counters
//   M_*                           : memory master port
module frag_zbuf_writer
   import gpu_pkg::*;
#(
   parameter int unsigned FB_WIDTH   = 640,
   parameter int unsigned FB_HEIGHT  = 480,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned FRAC_BITS  = 8,
   parameter bit          ZTEST_EN   = 1'b1
) (
   input  logic        CLK_clk,
   input  logic        RESET_reset,
   input  logic        frag_valid,
   output logic        frag_ready,
   input  logic [31:0] frag_x,
   input  logic [31:0] frag_y,
   input  logic [31:0] frag_z,
   input  logic [23:0] frag_rgb,
   input  logic [31:0] frame_pointer,
   input  logic [31:0] z_buffer_pointer,
   input  logic        clear_stats,
   output logic        busy,
   output logic [31:0] cnt_written,
   output logic [31:0] cnt_zfail,
   output logic [31:0] cnt_clipped,
   output logic [31:0] M_address,
   output logic        M_chipselect,
   output logic        M_read,
   output logic        M_write,
   output logic [31:0] M_writedata,
   input  logic [31:0] M_readdata,
   input  logic        M_readdatavalid,
   input  logic        M_waitrequest
);

   localparam logic signed [31:0] FB_W_S = 32'(FB_WIDTH);
   localparam logic signed [31:0] FB_H_S = 32'(FB_HEIGHT);
   localparam logic        [31:0] FB_W_U = 32'(FB_WIDTH);
   localparam logic        [31:0] PIX_U  = 32'(PIXEL_BYTES);

   state_t             r_state;
   state_t             w_state_nxt;
   frag_t              r_frag;
   frag_t              w_fifo_in;
   frag_t              w_fifo_out;
   logic               w_full;
   logic               w_empty;
   logic               w_pop;
   logic               w_push;
   logic signed [31:0] w_px;
   logic signed [31:0] w_py;
   logic               w_clip;
   logic        [31:0] w_offset;
   logic        [31:0] r_caddr;
   logic        [31:0] r_zaddr;
   logic               w_zpass;
   logic               w_inc_written;
   logic               w_inc_zfail;
   logic               w_inc_clipped;
   logic        [31:0] r_cnt_written;
   logic        [31:0] r_cnt_zfail;
   logic        [31:0] r_cnt_clipped;

   // Not ready while reset is held, so nothing is captured into a FIFO being cleared.
   assign frag_ready = ~w_full & ~RESET_reset;
   assign w_push     = frag_valid & frag_ready;

   always_comb begin
      w_fifo_in     = '0;
      w_fifo_in.x   = frag_x;
      w_fifo_in.y   = frag_y;
      w_fifo_in.z   = frag_z;
      w_fifo_in.rgb = frag_rgb;
   end

   frag_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (frag_t)
   ) u_fifo (
      .i_clk   (CLK_clk),
      .i_rst   (RESET_reset),
      .i_push  (w_push),
      .i_data  (w_fifo_in),
      .i_pop   (w_pop),
      .o_data  (w_fifo_out),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Pixel coordinates and byte offset of the working fragment (32-bit wrap-around).
   assign w_px     = $signed(r_frag.x) >>> FRAC_BITS;
   assign w_py     = $signed(r_frag.y) >>> FRAC_BITS;
   assign w_clip   = (w_px < 0) || (w_py < 0) || (w_px >= FB_W_S) || (w_py >= FB_H_S);
   assign w_offset = ($unsigned(w_py) * FB_W_U + $unsigned(w_px)) * PIX_U;

   // Strictly nearer wins; equal depth fails.
   assign w_zpass = $signed(r_frag.z) < $signed(M_readdata);

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = CHECK;
            end
         end
         CHECK: begin
            if (w_clip)        w_state_nxt = IDLE;
            else if (ZTEST_EN) w_state_nxt = ZREAD;
            else               w_state_nxt = CWRITE;
         end
         ZREAD: begin
            if (!M_waitrequest) w_state_nxt = ZWAIT;
         end
         ZWAIT: begin
            if (M_readdatavalid) w_state_nxt = w_zpass ? ZWRITE : IDLE;
         end
         ZWRITE: begin
            if (!M_waitrequest) w_state_nxt = CWRITE;
         end
         CWRITE: begin
            if (!M_waitrequest) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK_clk or posedge RESET_reset) begin
      if (RESET_reset) begin
         r_state <= IDLE;
         r_frag  <= '0;
         r_caddr <= '0;
         r_zaddr <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_pop) r_frag <= w_fifo_out;
         // Base pointers are captured once per fragment and held for its bus accesses.
         if (r_state == CHECK) begin
            r_caddr <= frame_pointer + w_offset;
            r_zaddr <= z_buffer_pointer + w_offset;
         end
      end
   end

   // Bus outputs decode from registered state only, so they hold steady under waitrequest.
   always_comb begin
      M_chipselect = 1'b0;
      M_read       = 1'b0;
      M_write      = 1'b0;
      M_address    = '0;
      M_writedata  = '0;
      unique case (r_state)
         ZREAD: begin
            M_chipselect = 1'b1;
            M_read       = 1'b1;
            M_address    = r_zaddr;
         end
         ZWRITE: begin
            M_chipselect = 1'b1;
            M_write      = 1'b1;
            M_address    = r_zaddr;
            M_writedata  = r_frag.z;
         end
         CWRITE: begin
            M_chipselect = 1'b1;
            M_write      = 1'b1;
            M_address    = r_caddr;
            M_writedata  = {8'h00, r_frag.rgb};
         end
         default: ;
      endcase
   end

   assign w_inc_written = (r_state == CWRITE) && !M_waitrequest;
   assign w_inc_zfail   = (r_state == ZWAIT) && M_readdatavalid && !w_zpass;
   assign w_inc_clipped = (r_state == CHECK) && w_clip;

   always_ff @(posedge CLK_clk or posedge RESET_reset) begin
      if (RESET_reset) begin
         r_cnt_written <= '0;
         r_cnt_zfail   <= '0;
         r_cnt_clipped <= '0;
      end else if (clear_stats) begin
         r_cnt_written <= '0;
         r_cnt_zfail   <= '0;
         r_cnt_clipped <= '0;
      end else begin
         if (w_inc_written) r_cnt_written <= r_cnt_written + 32'd1;
         if (w_inc_zfail)   r_cnt_zfail   <= r_cnt_zfail + 32'd1;
         if (w_inc_clipped) r_cnt_clipped <= r_cnt_clipped + 32'd1;
      end
   end

   assign cnt_written = r_cnt_written;
   assign cnt_zfail   = r_cnt_zfail;
   assign cnt_clipped = r_cnt_clipped;
   assign busy        = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_frag_zbuf_writer.sv
// Bench for frag_zbuf_writer: a depth-tested instance with a randomly stalling memory slave,
// and a colour-only instance fed the same accepted fragments. Expected bus transactions are
// queued by a reference model when a fragment is accepted; monitors pop and compare them.
`timescale 1ns/1ps
module tb_frag_zbuf_writer;
   import gpu_pkg::*;

   localparam int FBW  = 640;
   localparam int FBH  = 480;
   localparam int FRAC = 8;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   typedef struct {
      int          delay;
      logic [31:0] data;
   } rd_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frag_valid = 1'b0;
   logic [31:0] fx = '0, fy = '0, fz = '0;
   logic [23:0] frgb = '0;
   logic [31:0] fp = '0, zp = '0;
   logic        clr = 1'b0;

   logic        rdy, busy, mcs, mrd, mwr;
   logic [31:0] cw, cz, cc, maddr, mwd;
   logic [31:0] mrdata = '0;
   logic        mrdv = 1'b0, mwait = 1'b0;

   logic        nz_valid, nz_rdy, nz_busy, nz_cs, nz_rd, nz_wr;
   logic [31:0] nz_cw, nz_cz, nz_cc, nz_addr, nz_wd;

   always #5 clk = ~clk;

   // The colour-only instance only takes what the depth-tested instance takes.
   assign nz_valid = frag_valid & rdy;

   frag_zbuf_writer u_dut (
      .CLK_clk          (clk),
      .RESET_reset      (rst),
      .frag_valid       (frag_valid),
      .frag_ready       (rdy),
      .frag_x           (fx),
      .frag_y           (fy),
      .frag_z           (fz),
      .frag_rgb         (frgb),
      .frame_pointer    (fp),
      .z_buffer_pointer (zp),
      .clear_stats      (clr),
      .busy             (busy),
      .cnt_written      (cw),
      .cnt_zfail        (cz),
      .cnt_clipped      (cc),
      .M_address        (maddr),
      .M_chipselect     (mcs),
      .M_read           (mrd),
      .M_write          (mwr),
      .M_writedata      (mwd),
      .M_readdata       (mrdata),
      .M_readdatavalid  (mrdv),
      .M_waitrequest    (mwait)
   );

   frag_zbuf_writer #(.ZTEST_EN(1'b0)) u_dut_nz (
      .CLK_clk          (clk),
      .RESET_reset      (rst),
      .frag_valid       (nz_valid),
      .frag_ready       (nz_rdy),
      .frag_x           (fx),
      .frag_y           (fy),
      .frag_z           (fz),
      .frag_rgb         (frgb),
      .frame_pointer    (fp),
      .z_buffer_pointer (zp),
      .clear_stats      (clr),
      .busy             (nz_busy),
      .cnt_written      (nz_cw),
      .cnt_zfail        (nz_cz),
      .cnt_clipped      (nz_cc),
      .M_address        (nz_addr),
      .M_chipselect     (nz_cs),
      .M_read           (nz_rd),
      .M_write          (nz_wr),
      .M_writedata      (nz_wd),
      .M_readdata       (32'd0),
      .M_readdatavalid  (1'b0),
      .M_waitrequest    (1'b0)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   txn_t        exp_q[$];
   txn_t        nz_q[$];
   logic [31:0] rmem[logic [31:0]];
   logic [31:0] smem[logic [31:0]];
   int          m_written = 0, m_zfail = 0, m_clipped = 0, n_written = 0, n_clipped = 0;
   bit          model_clr = 1'b0;

   function automatic logic [31:0] init_depth(input logic [31:0] a);
      logic [31:0] p;
      p = a * 32'h9E37_79B1;
      return {22'd0, p[31:22]};
   endfunction

   task automatic model_push(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                             input logic [23:0] rgb);
      int          px, py;
      logic [31:0] off, ca, za, stored;
      px = int'(x) >>> FRAC;
      py = int'(y) >>> FRAC;
      if (px < 0 || py < 0 || px >= FBW || py >= FBH) begin
         if (!model_clr) begin
            m_clipped++;
            n_clipped++;
         end
         return;
      end
      off    = 32'((py * FBW + px) * 4);
      ca     = fp + off;
      za     = zp + off;
      stored = rmem.exists(za) ? rmem[za] : init_depth(za);
      exp_q.push_back('{1'b0, za, 32'd0});
      if ($signed(z) < $signed(stored)) begin
         exp_q.push_back('{1'b1, za, z});
         exp_q.push_back('{1'b1, ca, {8'h00, rgb}});
         rmem[za] = z;
         if (!model_clr) m_written++;
      end else if (!model_clr) begin
         m_zfail++;
      end
      nz_q.push_back('{1'b1, ca, {8'h00, rgb}});
      if (!model_clr) n_written++;
   endtask

   // ---------------- memory slave for the depth-tested instance ----------------
   bit  stall = 1'b0;
   bit  rd_hold = 1'b0;
   rd_t rd_q[$];

   initial begin
      forever begin : slave
         logic        acc_r, acc_w;
         logic [31:0] a, d;
         @(negedge clk);
         acc_r = mcs & mrd & ~mwait;
         acc_w = mcs & mwr & ~mwait;
         a     = maddr;
         d     = mwd;
         @(posedge clk);
         #1;
         if (rst) begin
            rd_q.delete();
            mrdv  = 1'b0;
            mwait = 1'b0;
            continue;
         end
         if (acc_w) smem[a] = d;
         if (acc_r) rd_q.push_back('{int'($urandom_range(0, 2)),
                                     smem.exists(a) ? smem[a] : init_depth(a)});
         mrdv   = 1'b0;
         mrdata = $urandom;
         if (rd_q.size() > 0 && !rd_hold) begin
            if (rd_q[0].delay == 0) begin
               mrdv   = 1'b1;
               mrdata = rd_q[0].data;
               void'(rd_q.pop_front());
            end else begin
               rd_q[0].delay--;
            end
         end
         mwait = stall ? 1'b1 : ($urandom_range(0, 3) == 0);
      end
   end

   // ---------------- monitors ----------------
   initial begin
      logic        p_hold;
      logic [31:0] p_addr, p_wd;
      logic [1:0]  p_rw;
      txn_t        t;
      p_hold = 1'b0;
      p_addr = '0;
      p_wd   = '0;
      p_rw   = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            p_hold = 1'b0;
            continue;
         end
         if (!mcs) chk("idle bus quiet", maddr | mwd | {30'd0, mrd, mwr}, 32'd0);
         if (p_hold) begin
            chk("hold addr", maddr, p_addr);
            chk("hold data", mwd, p_wd);
            chk("hold rw", {30'd0, mrd, mwr}, {30'd0, p_rw});
         end
         if (mcs && !mwait) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected txn: addr %h rd %b wr %b, expected none", maddr, mrd,
                        mwr);
            end else begin
               t = exp_q.pop_front();
               chk("txn rw", {30'd0, mrd, mwr}, {30'd0, ~t.wr, t.wr});
               chk("txn addr", maddr, t.addr);
               if (t.wr) chk("txn data", mwd, t.data);
            end
         end
         p_hold = mcs & mwait;
         p_addr = maddr;
         p_wd   = mwd;
         p_rw   = {mrd, mwr};
      end
   end

   initial begin
      txn_t t;
      forever begin
         @(negedge clk);
         if (rst) continue;
         if (!nz_cs) begin
            chk("nz idle bus quiet", nz_addr | nz_wd | {30'd0, nz_rd, nz_wr}, 32'd0);
         end else begin
            chk("nz no read", {31'd0, nz_rd}, 32'd0);
            checks++;
            if (nz_q.size() == 0) begin
               errors++;
               $display("FAIL nz unexpected write: addr %h data %h, expected none", nz_addr,
                        nz_wd);
            end else begin
               t = nz_q.pop_front();
               chk("nz write addr", nz_addr, t.addr);
               chk("nz write data", nz_wd, t.data);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                       input logic [23:0] rgb);
      int n;
      n = 0;
      @(negedge clk);
      fx         = x;
      fy         = y;
      fz         = z;
      frgb       = rgb;
      frag_valid = 1'b1;
      while (!rdy) begin
         @(negedge clk);
         n++;
         if (n > 500) begin
            checks++;
            errors++;
            $display("FAIL send timeout: ready 0 for %0d cycles, expected 1", n);
            frag_valid = 1'b0;
            return;
         end
      end
      chk("nz ready with main", {31'd0, nz_rdy}, 32'd1);
      model_push(x, y, z, rgb);
      @(posedge clk);
      #1;
      frag_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      while (exp_q.size() != 0 || nz_q.size() != 0 || busy || nz_busy) begin
         @(negedge clk);
         n++;
         if (n > 3000) begin
            checks++;
            errors++;
            $display("FAIL drain timeout: %0d txns pending, expected 0", exp_q.size());
            exp_q.delete();
            nz_q.delete();
            return;
         end
      end
   endtask

   task automatic check_counts();
      chk("cnt_written", cw, m_written);
      chk("cnt_zfail", cz, m_zfail);
      chk("cnt_clipped", cc, m_clipped);
      chk("nz cnt_written", nz_cw, n_written);
      chk("nz cnt_clipped", nz_cc, n_clipped);
      chk("nz cnt_zfail", nz_cz, 32'd0);
   endtask

   function automatic logic [31:0] fix(input int v);
      return 32'(v * (1 << FRAC));
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] off, za;
      int          px, py;
      repeat (3) @(negedge clk);
      chk("reset ready", {31'd0, rdy}, 32'd0);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset bus", maddr | mwd | {29'd0, mcs, mrd, mwr}, 32'd0);
      chk("reset counters", cw | cz | cc, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready after reset", {31'd0, rdy}, 32'd1);

      // Depth pass, then the identical fragment fails on equal depth.
      fp  = 32'h0000_1000;
      zp  = 32'h0008_0000;
      off = 32'((50 * FBW + 100) * 4);
      za  = zp + off;
      rmem[za] = 32'd20;
      smem[za] = 32'd20;
      send(fix(100), fix(50), 32'd10, 24'hFF8000);
      drain();
      chk("pass cnt_written", cw, 32'd1);
      send(fix(100), fix(50), 32'd10, 24'hFF8000);
      drain();
      chk("equal cnt_zfail", cz, 32'd1);

      // Clipped at both x edges.
      send(fix(-1), fix(10), 32'd5, 24'h123456);
      send(fix(640), fix(10), 32'd5, 24'h123456);
      drain();
      chk("clip cnt_clipped", cc, 32'd2);
      check_counts();

      // Long stall: four buffered plus one in flight, then back-pressure.
      stall = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) send(fix(10 + i), fix(7), 32'hFFFF_FF00, 24'(i + 1));
      @(negedge clk);
      chk("ready low after 5", {31'd0, rdy}, 32'd0);
      chk("busy during stall", {31'd0, busy}, 32'd1);
      repeat (14) @(negedge clk);
      chk("ready still low", {31'd0, rdy}, 32'd0);
      stall = 1'b0;
      send(fix(15), fix(7), 32'hFFFF_FF00, 24'd6);
      drain();
      check_counts();

      // Reset while waiting for read data.
      rd_hold = 1'b1;
      send(fix(20), fix(20), 32'h7FFF_FFFF, 24'hABCDEF);
      begin
         int n;
         n = 0;
         while ((exp_q.size() != 0 || nz_q.size() != 0 || nz_busy) && n < 200) begin
            @(negedge clk);
            n++;
         end
      end
      @(negedge clk);
      chk("in flight before reset", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid reset bus", maddr | mwd | {29'd0, mcs, mrd, mwr}, 32'd0);
      chk("mid reset busy", {31'd0, busy}, 32'd0);
      chk("mid reset counters", cw | cz | cc, 32'd0);
      chk("mid reset ready", {31'd0, rdy}, 32'd0);
      @(negedge clk);
      rst       = 1'b0;
      rd_hold   = 1'b0;
      exp_q.delete();
      m_written = 0;
      m_zfail   = 0;
      m_clipped = 0;
      n_written = 0;
      n_clipped = 0;
      send(fix(3), fix(3), 32'hFFFF_FF9C, 24'h00AA55);
      drain();
      check_counts();

      // Clear held across whole fragments: clear must win over increments.
      clr       = 1'b1;
      model_clr = 1'b1;
      m_written = 0;
      m_zfail   = 0;
      m_clipped = 0;
      n_written = 0;
      n_clipped = 0;
      send(fix(30), fix(30), 32'hFFFF_FF00, 24'h1);
      send(fix(-5), fix(30), 32'd0, 24'h2);
      send(fix(20), fix(20), 32'h7FFF_FFFF, 24'h3);
      drain();
      check_counts();
      clr       = 1'b0;
      model_clr = 1'b0;

      // Randomized traffic with pointer changes between batches.
      for (int b = 0; b < 4; b++) begin
         fp = $urandom & 32'hFFFF_FFFC;
         zp = $urandom & 32'hFFFF_FFFC;
         for (int i = 0; i < 40; i++) begin
            px = int'($urandom_range(0, 719)) - 40;
            py = int'($urandom_range(0, 539)) - 30;
            if ($urandom_range(0, 3) == 0) begin
               px = int'($urandom_range(0, 3));
               py = 0;
            end
            send(fix(px) | 32'($urandom_range(0, 255)), fix(py) | 32'($urandom_range(0, 255)),
                 32'($urandom_range(0, 1100)), 24'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         drain();
         check_counts();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
